// File: rtl/implode_unloader_if.sv
// ============================================================================
// Module  : implode_unloader_if
// Brief   : implode-result, state-BRAM and final-hash buses of the unloader.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface implode_unloader_if #(
  parameter int STATE_WIDTH     = 1600,
  parameter int BLOCK_WIDTH     = 1024,
  parameter int NONCE_WIDTH     = 7,
  parameter int BRAM_ADDR_WIDTH = 9
);
  logic                       i_valid;
  logic [NONCE_WIDTH-1:0]     i_v_nonce;
  logic [BLOCK_WIDTH-1:0]     i_v_block;
  logic                       o_ready;
  logic [BRAM_ADDR_WIDTH-1:0] o_v_addr;
  logic                       o_rd_en;
  logic [STATE_WIDTH-1:0]     i_v_rd_data;
  logic                       o_valid;
  logic                       i_ready;
  logic [STATE_WIDTH-1:0]     o_v_state;
  logic [NONCE_WIDTH-1:0]     o_v_nonce;
  logic                       o_done;

  modport slave (
    input  i_valid, i_v_nonce, i_v_block, i_v_rd_data, i_ready,
    output o_ready, o_v_addr, o_rd_en, o_valid, o_v_state, o_v_nonce, o_done
  );

  modport master (
    output i_valid, i_v_nonce, i_v_block, i_v_rd_data, i_ready,
    input  o_ready, o_v_addr, o_rd_en, o_valid, o_v_state, o_v_nonce, o_done
  );
endinterface

`default_nettype wire

// File: rtl/implode_unloader.sv
// ============================================================================
// Module  : implode_unloader
// Brief   : reads a hash's Keccak state from BRAM, merges the implode block,
//           and hands state + nonce to the final-hash stage.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module implode_unloader #(
  parameter int STATE_WIDTH     = 1600,
  parameter int BLOCK_WIDTH     = 1024,
  parameter int KEY_WIDTH       = 256,
  parameter int NONCE_WIDTH     = 7,
  parameter int BRAM_ADDR_WIDTH = 9,
  parameter int BRAM_RD_LATENCY = 1
) (
  input  wire                  clk,
  input  wire                  rstn,
  implode_unloader_if.slave    bus
);

  localparam int         c_MERGE_LO = 2 * KEY_WIDTH;
  localparam int         c_MERGE_HI = BLOCK_WIDTH + 2 * KEY_WIDTH - 1;
  localparam int         c_CNT_W    = 3;
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(BRAM_RD_LATENCY - 1);

  localparam int         c_ST_W = 2;
  localparam logic [c_ST_W-1:0] c_IDLE = 2'd0;
  localparam logic [c_ST_W-1:0] c_READ = 2'd1;
  localparam logic [c_ST_W-1:0] c_WAIT = 2'd2;
  localparam logic [c_ST_W-1:0] c_OUT  = 2'd3;

  logic [c_ST_W-1:0]          state_q,     state_d;
  logic [BLOCK_WIDTH-1:0]     block_reg_q, block_reg_d;
  logic [NONCE_WIDTH-1:0]     nonce_reg_q, nonce_reg_d;
  logic [STATE_WIDTH-1:0]     state_reg_q, state_reg_d;
  logic [c_CNT_W-1:0]         cnt_q,       cnt_d;
  logic [STATE_WIDTH-1:0]     w_merged;
  logic [BRAM_ADDR_WIDTH-1:0] w_addr;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      block_reg_q <= '0;
      nonce_reg_q <= '0;
      state_reg_q <= '0;
      cnt_q       <= '0;
    end else begin
      block_reg_q <= block_reg_d;
      nonce_reg_q <= nonce_reg_d;
      state_reg_q <= state_reg_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    block_reg_d = block_reg_q;
    nonce_reg_d = nonce_reg_q;
    state_reg_d = state_reg_q;
    cnt_d       = cnt_q;
    // BRAM word passes through except the block field, which the implode result replaces
    w_merged                        = bus.i_v_rd_data;
    w_merged[c_MERGE_HI:c_MERGE_LO] = block_reg_q;

    case (state_q)
      c_IDLE: begin
        if (bus.i_valid) begin
          block_reg_d = bus.i_v_block;
          nonce_reg_d = bus.i_v_nonce;
          state_d     = c_READ;
        end
      end
      c_READ: begin
        cnt_d   = c_CNT_LOAD;
        state_d = c_WAIT;
      end
      c_WAIT: begin
        if (cnt_q == '0) begin
          state_reg_d = w_merged;
          state_d     = c_OUT;
        end else begin
          cnt_d = cnt_q - c_CNT_W'(1);
        end
      end
      c_OUT: begin
        if (bus.i_ready) begin
          state_d = c_IDLE;
        end
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  generate
    if (BRAM_ADDR_WIDTH > NONCE_WIDTH) begin : g_addr_pad
      assign w_addr = {{(BRAM_ADDR_WIDTH - NONCE_WIDTH){1'b0}}, nonce_reg_q};
    end else begin : g_addr_exact
      assign w_addr = nonce_reg_q;
    end
  endgenerate

  // Outputs decode straight from state so an async reset clears them at once
  always_comb begin
    bus.o_ready   = (state_q == c_IDLE);
    bus.o_rd_en   = (state_q == c_READ);
    bus.o_valid   = (state_q == c_OUT);
    bus.o_done    = (state_q == c_OUT) && bus.i_ready;
    bus.o_v_addr  = w_addr;
    bus.o_v_state = state_reg_q;
    bus.o_v_nonce = nonce_reg_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_implode_unloader.sv
// ============================================================================
// Module  : tb_implode_unloader
// Brief   : directed bench for implode_unloader at read latencies 1 and 3.
// Rev     : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_implode_unloader;

  localparam int SW = 1600;
  localparam int BW = 1024;
  localparam int KW = 256;
  localparam int NW = 7;
  localparam int AW = 9;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  implode_unloader_if #(.STATE_WIDTH(SW), .BLOCK_WIDTH(BW), .NONCE_WIDTH(NW), .BRAM_ADDR_WIDTH(AW)) bus_a ();
  implode_unloader_if #(.STATE_WIDTH(SW), .BLOCK_WIDTH(BW), .NONCE_WIDTH(NW), .BRAM_ADDR_WIDTH(AW)) bus_b ();

  implode_unloader #(
    .STATE_WIDTH(SW), .BLOCK_WIDTH(BW), .KEY_WIDTH(KW), .NONCE_WIDTH(NW),
    .BRAM_ADDR_WIDTH(AW), .BRAM_RD_LATENCY(1)
  ) dut_a (.clk(clk), .rstn(rstn), .bus(bus_a.slave));

  implode_unloader #(
    .STATE_WIDTH(SW), .BLOCK_WIDTH(BW), .KEY_WIDTH(KW), .NONCE_WIDTH(NW),
    .BRAM_ADDR_WIDTH(AW), .BRAM_RD_LATENCY(3)
  ) dut_b (.clk(clk), .rstn(rstn), .bus(bus_b.slave));

  function automatic logic [SW-1:0] rand_wide();
    logic [SW-1:0] v;
    v = '0;
    for (int i = 0; i < SW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [31:0] fold32(input logic [SW-1:0] v);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < SW / 32; i++) f = f ^ v[i*32 +: 32];
    return f;
  endfunction

  // BRAM model: real data only on the cycles a read lands, junk elsewhere
  logic [SW-1:0] mem [0:(1<<AW)-1];
  logic [SW-1:0] pipe_a;
  logic [SW-1:0] pipe_b [0:2];
  int            reads_a = 0;
  int            reads_b = 0;
  logic [AW-1:0] last_addr_a = '0;

  always @(posedge clk) begin
    pipe_a    <= bus_a.o_rd_en ? mem[bus_a.o_v_addr] : rand_wide();
    pipe_b[0] <= bus_b.o_rd_en ? mem[bus_b.o_v_addr] : rand_wide();
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
    if (bus_a.o_rd_en) begin
      reads_a     <= reads_a + 1;
      last_addr_a <= bus_a.o_v_addr;
    end
    if (bus_b.o_rd_en) reads_b <= reads_b + 1;
  end

  assign bus_a.i_v_rd_data = pipe_a;
  assign bus_b.i_v_rd_data = pipe_b[2];

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus_a.o_ready, bus_a.o_valid, bus_a.o_rd_en, bus_a.o_done} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl: got rdy/vld/rd/done=%b want 1000",
               {bus_a.o_ready, bus_a.o_valid, bus_a.o_rd_en, bus_a.o_done});
    end
    checks++;
    if (bus_a.o_v_nonce !== 7'd0 || bus_a.o_v_addr !== 9'd0) begin
      errors++;
      $display("FAIL reset_nonce_addr: got nonce=%0d addr=%0d want 0 0", bus_a.o_v_nonce, bus_a.o_v_addr);
    end
    checks++;
    if (bus_a.o_v_state !== '0) begin
      errors++;
      $display("FAIL reset_state: got fold=%h want all zeros", fold32(bus_a.o_v_state));
    end
    checks++;
    if ({bus_b.o_ready, bus_b.o_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_b_ctrl: got rdy/vld=%b want 10", {bus_b.o_ready, bus_b.o_valid});
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [SW-1:0] exp;
    int            r0;
    exp = '0;
    exp[1535:512] = '1;
    mem[5] = '0;
    r0 = reads_a;
    bus_a.i_valid = 1'b1; bus_a.i_v_nonce = 7'd5; bus_a.i_v_block = '1; bus_a.i_ready = 1'b0;
    @(negedge clk);
    bus_a.i_valid = 1'b0; bus_a.i_v_block = '0;
    checks++;
    if ({bus_a.o_ready, bus_a.o_rd_en, bus_a.o_valid} !== 3'b010 || bus_a.o_v_addr !== 9'd5) begin
      errors++;
      $display("FAIL single_read: got rdy/rd/vld=%b addr=%0d want 010 addr=5",
               {bus_a.o_ready, bus_a.o_rd_en, bus_a.o_valid}, bus_a.o_v_addr);
    end
    @(negedge clk);
    checks++;
    if ({bus_a.o_rd_en, bus_a.o_valid} !== 2'b00) begin
      errors++;
      $display("FAIL single_wait: got rd/vld=%b want 00", {bus_a.o_rd_en, bus_a.o_valid});
    end
    @(negedge clk);
    checks++;
    if (bus_a.o_valid !== 1'b1) begin
      errors++;
      $display("FAIL single_valid_t3: got %b want 1", bus_a.o_valid);
    end
    checks++;
    if (bus_a.o_v_state !== exp || bus_a.o_v_nonce !== 7'd5) begin
      errors++;
      $display("FAIL single_data: got fold=%h nonce=%0d want fold=%h nonce=5",
               fold32(bus_a.o_v_state), bus_a.o_v_nonce, fold32(exp));
    end
    bus_a.i_ready = 1'b1;
    #1;
    checks++;
    if (bus_a.o_done !== 1'b1) begin
      errors++;
      $display("FAIL single_done: got %b want 1", bus_a.o_done);
    end
    @(negedge clk);
    checks++;
    if ({bus_a.o_done, bus_a.o_valid, bus_a.o_ready} !== 3'b001) begin
      errors++;
      $display("FAIL single_after: got done/vld/rdy=%b want 001",
               {bus_a.o_done, bus_a.o_valid, bus_a.o_ready});
    end
    bus_a.i_ready = 1'b0;
    checks++;
    if (reads_a - r0 != 1) begin
      errors++;
      $display("FAIL single_reads: got %0d want 1", reads_a - r0);
    end
  endtask

  task automatic test_backpressure();
    logic [SW-1:0] exp, tmp;
    logic [BW-1:0] b;
    int            waited;
    logic          stable;
    mem[9] = rand_wide();
    tmp = rand_wide();
    b = tmp[BW-1:0];
    exp = {mem[9][SW-1:1536], b, mem[9][511:0]};
    bus_a.i_valid = 1'b1; bus_a.i_v_nonce = 7'd9; bus_a.i_v_block = b; bus_a.i_ready = 1'b0;
    @(negedge clk);
    bus_a.i_valid = 1'b0;
    waited = 0;
    while (bus_a.o_valid !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (bus_a.o_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_timeout: o_valid=%b after %0d cycles want 1", bus_a.o_valid, waited);
    end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus_a.o_valid !== 1'b1 || bus_a.o_done !== 1'b0 ||
          bus_a.o_v_state !== exp || bus_a.o_v_nonce !== 7'd9) stable = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: got stable=%b want 1", stable);
    end
    checks++;
    if (bus_a.o_v_state !== exp) begin
      errors++;
      $display("FAIL bp_data: got fold=%h want fold=%h", fold32(bus_a.o_v_state), fold32(exp));
    end
    bus_a.i_ready = 1'b1;
    #1;
    checks++;
    if (bus_a.o_done !== 1'b1) begin
      errors++;
      $display("FAIL bp_done: got %b want 1", bus_a.o_done);
    end
    @(negedge clk);
    checks++;
    if ({bus_a.o_done, bus_a.o_valid} !== 2'b00) begin
      errors++;
      $display("FAIL bp_after: got done/vld=%b want 00", {bus_a.o_done, bus_a.o_valid});
    end
    bus_a.i_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] tmp, exp3, exp4;
    logic [BW-1:0] b3, b4;
    logic [7:0]    rdy_seen;
    int            addr_q[$];
    int            beat_n[$];
    logic [SW-1:0] beat_s[$];
    mem[3] = rand_wide(); tmp = rand_wide(); b3 = tmp[BW-1:0];
    mem[4] = rand_wide(); tmp = rand_wide(); b4 = tmp[BW-1:0];
    exp3 = {mem[3][SW-1:1536], b3, mem[3][511:0]};
    exp4 = {mem[4][SW-1:1536], b4, mem[4][511:0]};
    rdy_seen = '0;
    bus_a.i_valid = 1'b1; bus_a.i_v_nonce = 7'd3; bus_a.i_v_block = b3; bus_a.i_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin bus_a.i_v_nonce = 7'd4; bus_a.i_v_block = b4; end
      if (k == 5) bus_a.i_valid = 1'b0;
      #1;
      rdy_seen[k-1] = bus_a.o_ready;
      if (bus_a.o_rd_en) addr_q.push_back(int'(bus_a.o_v_addr));
      if (bus_a.o_valid && bus_a.i_ready) begin
        beat_n.push_back(int'(bus_a.o_v_nonce));
        beat_s.push_back(bus_a.o_v_state);
      end
    end
    bus_a.i_ready = 1'b0;
    checks++;
    if (rdy_seen !== 8'b1000_1000) begin
      errors++;
      $display("FAIL b2b_ready: got %b want 10001000", rdy_seen);
    end
    checks++;
    if (addr_q.size() != 2 || (addr_q.size() == 2 && (addr_q[0] != 3 || addr_q[1] != 4))) begin
      errors++;
      $display("FAIL b2b_reads: got %0d reads first=%0d want 2 reads 3,4",
               addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : -1);
    end
    checks++;
    if (beat_n.size() != 2) begin
      errors++;
      $display("FAIL b2b_beats: got %0d beats want 2", beat_n.size());
    end else begin
      checks++;
      if (beat_n[0] != 3 || beat_n[1] != 4) begin
        errors++;
        $display("FAIL b2b_order: got %0d,%0d want 3,4", beat_n[0], beat_n[1]);
      end
      checks++;
      if (beat_s[0] !== exp3 || beat_s[1] !== exp4) begin
        errors++;
        $display("FAIL b2b_data: got fold=%h,%h want fold=%h,%h",
                 fold32(beat_s[0]), fold32(beat_s[1]), fold32(exp3), fold32(exp4));
      end
    end
  endtask

  task automatic test_latency3();
    logic [SW-1:0] exp, tmp;
    logic [BW-1:0] b;
    int            r0;
    mem[20] = rand_wide(); tmp = rand_wide(); b = tmp[BW-1:0];
    exp = {mem[20][SW-1:1536], b, mem[20][511:0]};
    r0 = reads_b;
    bus_b.i_valid = 1'b1; bus_b.i_v_nonce = 7'd20; bus_b.i_v_block = b; bus_b.i_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus_b.i_valid = 1'b0;
        checks++;
        if (bus_b.o_rd_en !== 1'b1 || bus_b.o_v_addr !== 9'd20) begin
          errors++;
          $display("FAIL lat3_read: got rd=%b addr=%0d want 1 addr=20", bus_b.o_rd_en, bus_b.o_v_addr);
        end
      end
      if (k == 4) begin
        checks++;
        if (bus_b.o_valid !== 1'b0) begin
          errors++;
          $display("FAIL lat3_early: got o_valid=%b at t4 want 0", bus_b.o_valid);
        end
      end
    end
    checks++;
    if (bus_b.o_valid !== 1'b1 || bus_b.o_v_state !== exp || bus_b.o_v_nonce !== 7'd20) begin
      errors++;
      $display("FAIL lat3_data: got vld=%b fold=%h nonce=%0d want 1 fold=%h nonce=20",
               bus_b.o_valid, fold32(bus_b.o_v_state), bus_b.o_v_nonce, fold32(exp));
    end
    checks++;
    if (reads_b - r0 != 1) begin
      errors++;
      $display("FAIL lat3_reads: got %0d want 1", reads_b - r0);
    end
    bus_b.i_ready = 1'b1;
    @(negedge clk);
    bus_b.i_ready = 1'b0;
  endtask

  task automatic test_reset_midop();
    logic [SW-1:0] exp, tmp;
    logic [BW-1:0] b;
    logic          saw_valid;
    int            r0;
    mem[11] = rand_wide(); tmp = rand_wide(); b = tmp[BW-1:0];
    // reset while in WAIT
    bus_a.i_valid = 1'b1; bus_a.i_v_nonce = 7'd11; bus_a.i_v_block = b; bus_a.i_ready = 1'b0;
    @(negedge clk);
    bus_a.i_valid = 1'b0;
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({bus_a.o_ready, bus_a.o_valid, bus_a.o_rd_en, bus_a.o_done} !== 4'b1000 ||
        bus_a.o_v_state !== '0 || bus_a.o_v_nonce !== 7'd0) begin
      errors++;
      $display("FAIL rst_wait: got rdy/vld/rd/done=%b fold=%h nonce=%0d want 1000 zero state nonce 0",
               {bus_a.o_ready, bus_a.o_valid, bus_a.o_rd_en, bus_a.o_done},
               fold32(bus_a.o_v_state), bus_a.o_v_nonce);
    end
    @(negedge clk);
    rstn = 1'b1;
    saw_valid = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus_a.o_valid !== 1'b0) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_beat: got o_valid after reset=%b want 0", saw_valid);
    end
    // reset while in OUT with the handshake being offered
    bus_a.i_valid = 1'b1; bus_a.i_v_nonce = 7'd11; bus_a.i_v_block = b; bus_a.i_ready = 1'b0;
    @(negedge clk);
    bus_a.i_valid = 1'b0;
    repeat (2) @(negedge clk);
    bus_a.i_ready = 1'b1;
    #1;
    checks++;
    if ({bus_a.o_valid, bus_a.o_done} !== 2'b11) begin
      errors++;
      $display("FAIL rst_out_pre: got vld/done=%b want 11", {bus_a.o_valid, bus_a.o_done});
    end
    #1 rstn = 1'b0;
    #1;
    checks++;
    if ({bus_a.o_valid, bus_a.o_done, bus_a.o_ready} !== 3'b001 || bus_a.o_v_state !== '0) begin
      errors++;
      $display("FAIL rst_out: got vld/done/rdy=%b fold=%h want 001 zero state",
               {bus_a.o_valid, bus_a.o_done, bus_a.o_ready}, fold32(bus_a.o_v_state));
    end
    bus_a.i_ready = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    // fresh transaction at the top nonce
    mem[127] = rand_wide(); tmp = rand_wide(); b = tmp[BW-1:0];
    exp = {mem[127][SW-1:1536], b, mem[127][511:0]};
    r0 = reads_a;
    checks++;
    if (bus_a.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release_ready: got %b want 1", bus_a.o_ready);
    end
    bus_a.i_valid = 1'b1; bus_a.i_v_nonce = 7'd127; bus_a.i_v_block = b;
    @(negedge clk);
    bus_a.i_valid = 1'b0;
    checks++;
    if (bus_a.o_rd_en !== 1'b1 || bus_a.o_v_addr !== 9'd127) begin
      errors++;
      $display("FAIL n127_addr: got rd=%b addr=%0d want 1 addr=127", bus_a.o_rd_en, bus_a.o_v_addr);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (bus_a.o_valid !== 1'b1 || bus_a.o_v_state !== exp || bus_a.o_v_nonce !== 7'd127) begin
      errors++;
      $display("FAIL n127_data: got vld=%b fold=%h nonce=%0d want 1 fold=%h nonce=127",
               bus_a.o_valid, fold32(bus_a.o_v_state), bus_a.o_v_nonce, fold32(exp));
    end
    bus_a.i_ready = 1'b1;
    @(negedge clk);
    bus_a.i_ready = 1'b0;
    checks++;
    if (reads_a - r0 != 1 || last_addr_a !== 9'd127) begin
      errors++;
      $display("FAIL n127_reads: got %0d reads last addr=%0d want 1 read addr=127",
               reads_a - r0, last_addr_a);
    end
  endtask

  task automatic test_merge_boundary();
    logic [SW-1:0] r, tmp;
    logic [BW-1:0] b;
    r = rand_wide(); tmp = rand_wide(); b = tmp[BW-1:0];
    mem[42] = r;
    bus_a.i_valid = 1'b1; bus_a.i_v_nonce = 7'd42; bus_a.i_v_block = b; bus_a.i_ready = 1'b0;
    @(negedge clk);
    bus_a.i_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus_a.o_v_state[511:0] !== r[511:0]) begin
      errors++;
      $display("FAIL merge_low: got [63:0]=%h want %h", bus_a.o_v_state[63:0], r[63:0]);
    end
    checks++;
    if (bus_a.o_v_state[1535:512] !== b) begin
      errors++;
      $display("FAIL merge_block: got [575:512]=%h want %h", bus_a.o_v_state[575:512], b[63:0]);
    end
    checks++;
    if (bus_a.o_v_state[1599:1536] !== r[1599:1536]) begin
      errors++;
      $display("FAIL merge_high: got %h want %h", bus_a.o_v_state[1599:1536], r[1599:1536]);
    end
    bus_a.i_ready = 1'b1;
    @(negedge clk);
    bus_a.i_ready = 1'b0;
  endtask

  initial begin
    bus_a.i_valid = 1'b0; bus_a.i_v_nonce = '0; bus_a.i_v_block = '0; bus_a.i_ready = 1'b0;
    bus_b.i_valid = 1'b0; bus_b.i_v_nonce = '0; bus_b.i_v_block = '0; bus_b.i_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_latency3();
    test_reset_midop();
    test_merge_boundary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
